mult_seq_ctrl: RTL and testbench

Iterative shift-add multiplier sequencer for MULT/MULTU. It performs a WIDTH-cycle multiply by time-sharing one external carry-lookahead adder built from CLA4 slices. It drives the adder operands, captures sum/carry, and shifts the product register. It sits beside the ALU in EX and writes the HI/LO result registers.

---
 rtl/mult_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - Shift-add MULT/MULTU sequencer sharing an external CLA adder; optional MULT_EARLY_TERM_EN
module mult_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [2*WIDTH-1:0]   r_p;
    logic [WIDTH-1:0]     r_mcand;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_step;
    logic [2*WIDTH-1:0]   w_calc_p;
    logic [2*WIDTH-1:0]   w_final;
    logic                 w_last;

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Operand magnitudes; MULTU operands pass through untouched. The most
    // negative value maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        w_mag_a = op_a;
        w_mag_b = op_b;
        if (is_signed && op_a[WIDTH-1]) begin
            w_mag_a = ~op_a + WIDTH'(1);
        end
        if (is_signed && op_b[WIDTH-1]) begin
            w_mag_b = ~op_b + WIDTH'(1);
        end
    end

    // One shift-add step: add the multiplicand into the high word when the
    // current multiplier bit is set, then shift the whole product right.
    always_comb begin
        w_step = {1'b0, r_p[2*WIDTH-1:1]};
        if (r_p[0]) begin
            w_step = {add_cout, add_sum, r_p[WIDTH-1:1]};
        end
    end

`ifdef MULT_EARLY_TERM_EN
    logic [CW-1:0]    w_shamt;
    logic [WIDTH-1:0] w_rem_mask;
    logic             w_rem_zero;

    // Finish early once no set multiplier bits remain: the remaining steps
    // would only shift, so they collapse into one bulk shift.
    always_comb begin
        w_shamt    = LAST_CNT - r_cnt;
        w_rem_mask = {WIDTH{1'b1}} >> r_cnt;
        w_rem_zero = ((r_p[WIDTH-1:0] & w_rem_mask) >> 1) == '0;
        w_last     = w_rem_zero || (r_cnt == LAST_CNT);
        w_calc_p   = w_step;
        if (w_rem_zero) begin
            w_calc_p = w_step >> w_shamt;
        end
    end
`else
    // Fixed-length iteration: exactly WIDTH steps.
    always_comb begin
        w_last   = (r_cnt == LAST_CNT);
        w_calc_p = w_step;
    end
`endif

    // Final sign fix-up of the full double-width product.
    always_comb begin
        w_final = r_p;
        if (r_neg) begin
            w_final = ~r_p + (2*WIDTH)'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and adder operand drive; the adder sees zeros outside CALC.
    always_comb begin
        w_state_nx = r_state;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_CALC;
                end
            end
            S_CALC: begin
                add_a = r_p[2*WIDTH-1:WIDTH];
                add_b = r_mcand;
                if (w_last) begin
                    w_state_nx = S_SIGN;
                end
            end
            S_SIGN: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, product iteration, result write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p     <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand <= w_mag_a;
                        r_p     <= {{WIDTH{1'b0}}, w_mag_b};
                        r_neg   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        r_cnt   <= '0;
                    end
                end
                S_CALC: begin
                    r_p   <= w_calc_p;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_SIGN: begin
                    r_hi   <= w_final[2*WIDTH-1:WIDTH];
                    r_lo   <= w_final[WIDTH-1:0];
                    r_done <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - Self-checking bench for mult_seq_ctrl (vectors, corner sequences, random vs model)
module tb_mult_seq_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] add_sum;
    logic         add_cout;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vt[9];

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic int msb_idx(input logic [W-1:0] x);
        for (int i = W - 1; i >= 0; i--) begin
            if (x[i]) return i;
        end
        return -1;
    endfunction

    // Edges from the start edge until the edge that raises done.
    function automatic int ref_lat(input logic [W-1:0] b, input logic sgn);
`ifdef MULT_EARLY_TERM_EN
        logic [W-1:0] mb;
        int c;
        mb = (sgn && b[W-1]) ? (~b + 32'd1) : b;
        c = msb_idx(mb) + 1;
        if (c < 1) c = 1;
        return c + 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, input int inj,
                          output int lat, output int busy_cycles, output logic [W-1:0] r_hi,
                          output logic [W-1:0] r_lo, output logic held_ok, output logic busy_in_done);
        op_a = a;
        op_b = b;
        is_signed = sgn;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        lat = -1;
        busy_cycles = 0;
        held_ok = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            if (hi !== exp_hi || lo !== exp_lo) held_ok = 1'b0;
            if (busy) busy_cycles++;
            if (n == inj) begin
                start = 1'b1;
                op_a = 32'd1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        r_hi = hi;
        r_lo = lo;
        busy_in_done = busy;
    endtask

    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input int inj, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int lat;
        int bc;
        logic [W-1:0] rh;
        logic [W-1:0] rl;
        logic hold;
        logic bd;
        int el;
        el = ref_lat(b, sgn);
        run_op(a, b, sgn, inj, lat, bc, rh, rl, hold, bd);
        check({name, ".latency"}, 64'(lat), 64'(el));
        check({name, ".hi"}, 64'(rh), 64'(ehi));
        check({name, ".lo"}, 64'(rl), 64'(elo));
        check({name, ".hold_old"}, 64'(hold), 64'd1);
        check({name, ".busy_cycles"}, 64'(bc), 64'(el));
        check({name, ".busy_in_done"}, 64'(bd), 64'd0);
        exp_hi = ehi;
        exp_lo = elo;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [63:0] p;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic s;
        int dcount;
        logic zero_ok;

        vt[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        vt[1] = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vt[2] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
        vt[3] = '{32'h0000000A, 32'h00000005, 1'b0, 32'h00000000, 32'h00000032};
        vt[4] = '{32'h00000005, 32'h00000001, 1'b0, 32'h00000000, 32'h00000005};
        vt[5] = '{32'h00000005, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000};
        vt[6] = '{32'h00000001, 32'h80000000, 1'b0, 32'h00000000, 32'h80000000};
        vt[7] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000};
        vt[8] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 32'hC0000000, 32'h80000000};

        rst = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        op_a = '0;
        op_b = '0;
        exp_hi = '0;
        exp_lo = '0;
        #12;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.lo", 64'(lo), 64'd0);
        check("reset.add_a", 64'(add_a), 64'd0);
        check("reset.add_b", 64'(add_b), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Vector table; consecutive entries also start in each other's done cycle.
        for (int i = 0; i < 9; i++) begin
            do_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].sgn, -1, vt[i].hi, vt[i].lo);
        end

        // Back-to-back: 2*3 started in the done cycle of 0xFFFFFFFF^2.
        do_op("b2b_first", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, 32'hFFFFFFFE, 32'h00000001);
        do_op("b2b_second", 32'd2, 32'd3, 1'b0, -1, 32'd0, 32'd6);

        // Start while busy must be ignored; exactly one done pulse.
        do_op("ignore_start", 32'h0000000A, 32'h00000005, 1'b0, 10, 32'd0, 32'h32);
        @(posedge clk);
        #1;
        check("ignore_start.single_done", 64'(done), 64'd0);
        check("ignore_start.idle_after", 64'(busy), 64'd0);

        // Reset mid-operation aborts immediately with no done pulse.
        op_a = 32'h1234;
        op_b = 32'h5678;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.hi", 64'(hi), 64'd0);
        check("abort.lo", 64'(lo), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        dcount = 0;
        zero_ok = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
            if (hi !== '0 || lo !== '0) zero_ok = 1'b0;
        end
        check("abort.no_done", 64'(dcount), 64'd0);
        check("abort.result_zero", 64'(zero_ok), 64'd1);
        do_op("after_abort", 32'h1234, 32'h5678, 1'b0, -1, 32'd0, 32'h06260060);

        // Randomized operations against the arithmetic reference model.
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(0, 15));
                2: b = 32'd1 << $urandom_range(0, 31);
                default: b = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'hFFFFFFFF;
            endcase
            s = 1'($urandom_range(0, 1));
            p = ref_prod(a, b, s);
            do_op($sformatf("rand%0d", i), a, b, s, -1, p[63:32], p[31:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
